// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Types and constants shared by the UART core and the TX arbiter.
//   arb_state_t     : arbiter FSM encoding (IDLE / LOCK)
//   DEF_DATA_WIDTH  : default byte width, matches the UART DBIT setting
//   ptr_width()     : width of a requester index for n requesters
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Picks the first asserted request at or
// after rr_ptr, searching upward and wrapping past NREQ-1 to 0.
// Ports:
//   req    in  [NREQ]   request vector
//   rr_ptr in  [PTR_W]  index with the highest priority this round
//   pick   out [NREQ]   one-hot winner (zero when nothing requests)
//   found  out          at least one request was asserted
// ---------------------------------------------------------------------------
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  pick,
    output logic             found
);

    // Two passes avoid a computed (modulo) index: first the requesters at or
    // above the pointer, then the wrapped-around ones below it.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= int'(rr_ptr))) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i < int'(rr_ptr))) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin, packet-locking arbiter in front of the UART TX FIFO write port.
// A granted requester owns the port until it sends a byte flagged last, so
// multi-byte messages never interleave on the serial line.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to add a stall-timeout counter
// that force-releases a lock after TIMEOUT stalled cycles and pulses the
// extra timeout_err output.
//
// Ports:
//   clk          in               system clock
//   rst          in               asynchronous active-low reset
//   req_valid    in  [NREQ]       per-requester byte valid
//   req_data     in  [NREQ*DW]    packed bytes, requester i at [i*DW +: DW]
//   req_last     in  [NREQ]       final byte of a message
//   req_ready    out [NREQ]       byte accepted when valid & ready
//   tx_full      in               UART TX FIFO full
//   wr_uart      out              UART FIFO write strobe
//   w_data       out [DW]         byte to the UART FIFO
//   grant        out [NREQ]       one-hot owner, zero when idle
//   timeout_err  out              (UART_ARB_TIMEOUT_EN only) one-cycle pulse
//   busy         out              a grant is held
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TO_W       = 8,
    parameter int TIMEOUT    = 200
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]            req_last,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       tx_full,
    output logic                       wr_uart,
    output logic [DATA_WIDTH-1:0]      w_data,
    output logic [NREQ-1:0]            grant,
`ifdef UART_ARB_TIMEOUT_EN
    output logic                       timeout_err,
`endif
    output logic                       busy
);

    localparam int PTR_W = ptr_width(NREQ);

    // Elaboration-time guard: the stall limit must fit the counter.
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT >= (2 ** TO_W)) begin : g_bad_params
        $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT in 1..2^TO_W-1");
    end

    arb_state_t       state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0]       pick;
    logic                  found;
    logic [PTR_W-1:0]      g_idx;
    logic [PTR_W-1:0]      next_ptr;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_err_q, timeout_err_d;
`endif

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .pick   (pick),
        .found  (found)
    );

    // Mux the owner's handshake signals out of the packed request bus.
    always_comb begin
        g_idx     = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                g_idx     = PTR_W'(i);
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        next_ptr = (int'(g_idx) == NREQ - 1) ? '0 : g_idx + 1'b1;
    end

    // Next-state and port logic. A stalled owner (valid low) keeps the lock;
    // only a last byte, or the optional timeout, hands the port back.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        req_ready = '0;
        wr_uart   = 1'b0;
        w_data    = '0;
`ifdef UART_ARB_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                if (found) begin
                    grant_d = pick;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                req_ready = grant_q & {NREQ{~tx_full}};
                wr_uart   = sel_valid & ~tx_full;
                if (wr_uart) begin
                    w_data = sel_data;
                end
                if (wr_uart && sel_last) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (wr_uart) begin
                    to_cnt_d = '0;
                end else if (!tx_full && !sel_valid) begin
                    if (to_cnt_q == TO_LIMIT) begin
                        state_d       = IDLE;
                        grant_d       = '0;
                        rr_ptr_d      = next_ptr;
                        to_cnt_d      = '0;
                        timeout_err_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == LOCK);
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (NREQ=4, 8-bit data). Directed
// vector tables for single-message and tx_full-stall cases, plus hand-written
// sequences for round-robin ordering, reset mid-message and, when
// UART_ARB_TIMEOUT_EN is defined, the stall timeout.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0] req_last;
    logic [NREQ-1:0] req_ready;
    logic            tx_full;
    logic            wr_uart;
    logic [DW-1:0]   w_data;
    logic [NREQ-1:0] grant;
    logic            busy;
`ifdef UART_ARB_TIMEOUT_EN
    logic            timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NREQ       (NREQ),
        .DATA_WIDTH (DW),
        .TO_W       (8),
        .TIMEOUT    (200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_full     (tx_full),
        .wr_uart     (wr_uart),
        .w_data      (w_data),
        .grant       (grant),
`ifdef UART_ARB_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs expected in that same cycle.
    typedef struct {
        logic [NREQ-1:0]    valid;
        logic [NREQ*DW-1:0] data;
        logic [NREQ-1:0]    last;
        logic               full;
        logic [NREQ-1:0]    e_grant;
        logic               e_busy;
        logic               e_wr;
        logic [DW-1:0]      e_wdata;
        logic [NREQ-1:0]    e_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                                input logic f, input logic [3:0] eg, input logic eb,
                                input logic ew, input logic [7:0] ed, input logic [3:0] er);
        vec_t t;
        t.valid = v; t.data = d; t.last = l; t.full = f;
        t.e_grant = eg; t.e_busy = eb; t.e_wr = ew; t.e_wdata = ed; t.e_ready = er;
        return t;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t t);
        req_valid = t.valid;
        req_data  = t.data;
        req_last  = t.last;
        tx_full   = t.full;
    endtask

    task automatic checkOutput(input vec_t t, input string tag);
        checkVal({tag, " grant"},     32'(grant),     32'(t.e_grant));
        checkVal({tag, " busy"},      32'(busy),      32'(t.e_busy));
        checkVal({tag, " wr_uart"},   32'(wr_uart),   32'(t.e_wr));
        checkVal({tag, " w_data"},    32'(w_data),    32'(t.e_wdata));
        checkVal({tag, " req_ready"}, 32'(req_ready), 32'(t.e_ready));
    endtask

    task automatic runTable(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], $sformatf("%s[%0d]", tag, i));
        end
    endtask

    // Reset with every requester asserting valid: nothing may leak through.
    task automatic doReset();
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '1;
        req_data  = 32'h11223344;
        req_last  = '0;
        tx_full   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkVal("reset grant",     32'(grant),     0);
        checkVal("reset busy",      32'(busy),      0);
        checkVal("reset wr_uart",   32'(wr_uart),   0);
        checkVal("reset w_data",    32'(w_data),    0);
        checkVal("reset req_ready", 32'(req_ready), 0);
`ifdef UART_ARB_TIMEOUT_EN
        checkVal("reset timeout_err", 32'(timeout_err), 0);
`endif
        @(negedge clk);
        req_valid = '0;
        req_data  = '0;
        rst       = 1'b1;
    endtask

    initial begin
        int cnt[NREQ];
        int k, ph, owner;
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_full   = 1'b0;

        // Single requester 0 sends 0x48, 0x69(last).
        doReset();
        vecs.delete();
        vecs.push_back(mk(4'b0001, 32'h48, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000));
        vecs.push_back(mk(4'b0001, 32'h48, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1, 8'h48, 4'b0001));
        vecs.push_back(mk(4'b0001, 32'h69, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 8'h69, 4'b0001));
        vecs.push_back(mk(4'b0000, 32'h00, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000));
        runTable("single");

        // tx_full held high for 5 cycles after the first byte of requester 1.
        doReset();
        vecs.delete();
        vecs.push_back(mk(4'b0010, 32'h0000A000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000));
        vecs.push_back(mk(4'b0010, 32'h0000A000, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b1, 8'hA0, 4'b0010));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(4'b0010, 32'h0000A100, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, 8'h00, 4'b0000));
        vecs.push_back(mk(4'b0010, 32'h0000A100, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b1, 8'hA1, 4'b0010));
        vecs.push_back(mk(4'b0010, 32'h0000A200, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 8'hA2, 4'b0010));
        vecs.push_back(mk(4'b0000, 32'h00000000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000));
        runTable("txfull");

        // All four requesters, two 2-byte messages each. Byte j of requester
        // i is i*16+j; a 3-cycle period (idle, byte, last byte) is expected.
        doReset();
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i]         = (cnt[i] < 4);
                req_data[i*DW +: DW] = 8'(i * 16 + cnt[i]);
                req_last[i]          = (cnt[i] % 2 == 1);
            end
            #1;
            k  = c / 3;
            ph = c % 3;
            if (ph == 0) begin
                checkVal($sformatf("rr c%0d grant", c),   32'(grant),   0);
                checkVal($sformatf("rr c%0d wr_uart", c), 32'(wr_uart), 0);
            end else begin
                owner = k % 4;
                checkVal($sformatf("rr c%0d grant", c),     32'(grant),     32'(1 << owner));
                checkVal($sformatf("rr c%0d req_ready", c), 32'(req_ready), 32'(1 << owner));
                checkVal($sformatf("rr c%0d wr_uart", c),   32'(wr_uart),   1);
                checkVal($sformatf("rr c%0d w_data", c),    32'(w_data),
                         32'(owner * 16 + (k / 4) * 2 + (ph - 1)));
            end
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && req_ready[i]) cnt[i]++;
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checkVal("rr done busy", 32'(busy), 0);

        // Requester 2 sends a one-byte message (rr_ptr -> 3), requester 0
        // then wins by wrap-around, and reset lands after its first byte.
        doReset();
        @(negedge clk);
        req_valid = 4'b0100; req_data = 32'h00220000; req_last = 4'b0100;
        #1;
        checkVal("rst seq idle grant", 32'(grant), 0);
        @(negedge clk); #1;
        checkVal("rst seq r2 grant",  32'(grant),  32'b0100);
        checkVal("rst seq r2 w_data", 32'(w_data), 32'h22);
        @(negedge clk);
        req_valid = '0; req_last = '0;
        #1;
        checkVal("rst seq r2 released", 32'(busy), 0);
        @(negedge clk);
        req_valid = 4'b0001; req_data = 32'h31;
        @(negedge clk); #1;
        checkVal("rst seq wrap grant",  32'(grant),  32'b0001);
        checkVal("rst seq wrap w_data", 32'(w_data), 32'h31);
        @(negedge clk);
        req_data = 32'h32;
        rst      = 1'b0;
        #1;
        checkVal("rst async wr_uart",   32'(wr_uart),   0);
        checkVal("rst async w_data",    32'(w_data),    0);
        checkVal("rst async req_ready", 32'(req_ready), 0);
        checkVal("rst async grant",     32'(grant),     0);
        checkVal("rst async busy",      32'(busy),      0);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b1001;
        req_data  = 32'h99000031;
        #1;
        checkVal("rst after idle", 32'(grant), 0);
        @(negedge clk); #1;
        checkVal("rst after grant",  32'(grant),  32'b0001);
        checkVal("rst after w_data", 32'(w_data), 32'h31);

`ifdef UART_ARB_TIMEOUT_EN
        // Requester 2 locks, sends one byte, then stalls; requester 3 waits.
        begin
            int pulses, pulse_at, bad_wr;
            pulses = 0; pulse_at = -1; bad_wr = 0;
            doReset();
            @(negedge clk);
            req_valid = 4'b1100; req_data = 32'h77550000; req_last = 4'b1000;
            @(negedge clk); #1;
            checkVal("to lock grant", 32'(grant), 32'b0100);
            checkVal("to first byte", 32'(w_data), 32'h55);
            for (int n = 1; n <= 210; n++) begin
                @(negedge clk);
                if (n == 1) req_valid = 4'b1000;
                #1;
                if (timeout_err) begin
                    pulses++;
                    if (pulse_at < 0) pulse_at = n;
                end
                if (n <= 201 && wr_uart) bad_wr++;
                if (n == 200) checkVal("to held grant", 32'(grant), 32'b0100);
                if (n == 202) checkVal("to next grant", 32'(grant), 32'b1000);
            end
            checkVal("to pulse count", 32'(pulses), 1);
            checkVal("to pulse cycle", 32'(pulse_at), 201);
            checkVal("to stall writes", 32'(bad_wr), 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locking arbiter that shares the single UART transmit FIFO among `NREQ` byte-stream requesters. Sits between on-chip message sources (command responder, status reporter, echo path, …) and the `uart` core's `wr_uart`/`w_data`/`tx_full` write port. Once a requester is granted, it owns the port until it sends a byte flagged `last`, so multi-byte messages never interleave on the serial line.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 8: byte width; matches the UART `DBIT`.
- `TO_W`, 8: width of the stall-timeout counter.
- `TIMEOUT`, 200: cycles of requester stall before a forced release; must be < 2^`TO_W`.
- `clk` in, 1: system clock.
- `rst` in, 1: asynchronous, active-low reset.
- `req_valid` in, `NREQ`: per-requester byte valid.
- `req_data` in, `NREQ*DATA_WIDTH`: packed bytes; requester i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_last` in, `NREQ`: marks the final byte of a message.
- `req_ready` out, `NREQ`: byte accepted when `req_valid[i] & req_ready[i]`.
- `tx_full` in, 1: UART TX FIFO full.
- `wr_uart` out, 1: UART FIFO write strobe.
- `w_data` out, `DATA_WIDTH`: byte to UART FIFO.
- `grant` out, `NREQ`: one-hot current owner; all zero when idle.
- `busy` out, 1: a grant is held.

## Operation
- FSM states: `IDLE`, `LOCK`.
- `IDLE`:
  - If any `req_valid` is high, select the first requester at or after `rr_ptr`, searching upward with wrap.
  - Register the one-hot `grant` and go to `LOCK`.
  - No byte transfers in the arbitration cycle.
- `LOCK`:
  - `req_ready[g] = !tx_full`; every other `req_ready` is 0.
  - `wr_uart = req_valid[g] & !tx_full`.
  - `w_data = req_data[g]` when `wr_uart` is high, otherwise 0.
- Transfer with `req_last[g]=1`: `LOCK -> IDLE`, `grant` cleared, `rr_ptr = (g+1) mod NREQ`.
- Requester drops `req_valid` mid-message: the lock is held and the arbiter idles in bubbles. Only the timeout (see Configuration) can break the lock.
- `tx_full=1`: no write and no ready. The byte stays pending on the requester side; nothing is lost or duplicated.
- New requests arriving during `LOCK` wait. Their order is decided only at the next `IDLE` arbitration.
- `rr_ptr` wraps from `NREQ-1` to 0.
- Reset mid-message: the partial message is abandoned. `rr_ptr=0`, FSM goes to `IDLE`.

## Timing
- Reset values: `wr_uart=0`, `w_data=0`, `req_ready=0`, `grant=0`, `busy=0`, `timeout_err=0`, `rr_ptr=0`, FSM `IDLE`.
- Grant latency: `req_valid` seen in `IDLE` at edge n gives `grant`/`busy` valid after edge n+1. The first transfer can occur in the cycle following edge n+1.
- Throughput: 1 byte/cycle while locked, `req_valid=1` and `tx_full=0`.
- `wr_uart`, `w_data` and `req_ready` are combinational from `tx_full` and `req_valid[g]`. `grant`, `busy` and the FSM are registered.
- Back-to-back messages cost one idle arbitration cycle between the `last` byte and the next grant.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A `TO_W`-bit counter runs in `LOCK`. It increments on cycles with `req_valid[g]=0`, resets on any transfer, and holds while `tx_full=1`.
  - When it reaches `TIMEOUT`: force `LOCK -> IDLE`, `rr_ptr = g+1`, and pulse the extra output `timeout_err` (1 bit) high for one cycle.
- Undefined: no counter and no `timeout_err` port. A lock is held indefinitely until `last`.

## Structure
- Package `uart_pkg`: `arb_state_t` enum (`IDLE`, `LOCK`), and the `DATA_WIDTH` default shared with `uart`.
- One sub-module, `rr_pick`: combinational round-robin selector. Inputs are the request vector and `rr_ptr`; outputs are a one-hot pick and a `found` flag.
- The arbiter instantiates `rr_pick` and holds the FSM, the grant register, `rr_ptr` and the timeout counter.

## Test plan
- Single requester 0 sends 0x48, 0x69 (`last`) with `tx_full=0`:
  - `grant=0001` one cycle after valid.
  - Two consecutive `wr_uart` pulses with `w_data` 0x48 then 0x69.
  - Then `busy=0`.
- All four valid, each with 2-byte messages:
  - Grant order 0, 1, 2, 3, then 0 again.
  - No interleaving of bytes; exactly one idle cycle between messages.
- `tx_full` held high for 5 cycles mid-message:
  - `wr_uart=0` and `req_ready=0` for those 5 cycles.
  - Byte resumes unchanged with no duplicate write.
- Requester 2 locked then drops valid for 300 cycles, `TIMEOUT=200`, with `UART_ARB_TIMEOUT_EN` defined:
  - `timeout_err` pulses exactly once at stall cycle 200.
  - Pending requester 3 is granted next.
- Assert `rst` low after the first byte of a 3-byte message:
  - All outputs go to 0 immediately.
  - After release, requester 0 wins arbitration again (`rr_ptr=0`).
